// File: rtl/cim_row_sequencer_pkg.sv
// Shared types for the CIM wordline sequencer.
//   mode_t    : command mode encoding carried on cmd_mode
//   state_t   : sequencer FSM states, also exported on the debug port
//   cnt_width : width of the PRE/ACT cycle counter for a given timing pair
//   *_DEF     : default timing used by the top-level parameters
package cim_pkg;

  typedef enum logic [1:0] {
    MODE_WRITE = 2'b00,
    MODE_MAC   = 2'b01,
    MODE_CAM   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PRE  = 2'b01,
    S_ACT  = 2'b10
  } state_t;

  localparam int PRE_CYC_DEF   = 1;
  localparam int PULSE_CYC_DEF = 2;

  // Counter must hold values 0 .. max(pre, pulse) - 1; sized with one spare
  // so a single-cycle phase still gets a 1-bit counter.
  function automatic int cnt_width(input int pre_cyc, input int pulse_cyc);
    int m;
    m = (pre_cyc > pulse_cyc) ? pre_cyc : pulse_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cim_row_sequencer_if.sv
// Command interface of the wordline sequencer.
//   cmd_valid / cmd_ready : handshake
//   cmd_mode, cmd_addr, cmd_cnt, cmd_read_bar, cmd_key : command payload
// Handshake: a command transfers at a rising clk edge where cmd_valid and
// cmd_ready are both high. The master holds the payload stable while
// cmd_valid is high and cmd_ready is low; cmd_ready does not depend on
// cmd_valid. The payload is don't-care after the transfer edge.
interface cim_row_sequencer_if #(
  parameter int ROWS = 16,
  parameter int AW   = $clog2(ROWS)
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_mode;
  logic [AW-1:0]   cmd_addr;
  logic [AW-1:0]   cmd_cnt;
  logic            cmd_read_bar;
  logic [ROWS-1:0] cmd_key;

  modport master (
    output cmd_valid, cmd_mode, cmd_addr, cmd_cnt, cmd_read_bar, cmd_key,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_addr, cmd_cnt, cmd_read_bar, cmd_key,
    output cmd_ready
  );
endinterface

// File: rtl/cim_row_sequencer_onehot.sv
// Row address decoder.
//   addr   : row address (AW bits)
//   onehot : one-hot row select; all zeros when addr >= ROWS
module cim_row_onehot #(
  parameter int ROWS = 16,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic [AW-1:0]   addr,
  output logic [ROWS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (addr == AW'(i)) onehot[i] = 1'b1;
    end
  end
endmodule

// File: rtl/cim_row_sequencer.sv
// Wordline sequencer for the CIM macro. Accepts WRITE / MAC / CAM commands
// and frames every activation with a precharge gap (all lines low) followed
// by a registered pulse, so WL/WLB never glitch.
//   clk, rst        : clock, synchronous active-high reset
//   cs              : chip select; low aborts any operation in flight
//   cmd (slave)     : command handshake and payload
//   WL, WLB         : registered wordlines
//   row_idx         : row being precharged / pulsed
//   busy            : high outside IDLE
//   done, err       : one-cycle completion / reject-or-abort pulses
//   dbg_state       : current FSM state
module cim_row_sequencer
  import cim_pkg::*;
#(
  parameter int ROWS      = 16,
  parameter int AW        = $clog2(ROWS),
  parameter int PRE_CYC   = PRE_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  cim_row_sequencer_if.slave  cmd,
  output logic [ROWS-1:0]     WL,
  output logic [ROWS-1:0]     WLB,
  output logic [AW-1:0]       row_idx,
  output logic                busy,
  output logic                done,
  output logic                err,
  output state_t              dbg_state
);
  localparam int             CW         = cnt_width(PRE_CYC, PULSE_CYC);
  localparam int             AW1        = AW + 1;
  localparam logic [CW-1:0]  PRE_LAST   = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [AW-1:0]  ROW_LAST   = AW'(ROWS - 1);
  localparam logic [AW1-1:0] ROWS_EXT   = AW1'(ROWS);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   left_q, left_d;     // rows still to visit after this one
  mode_t           mode_q, mode_d;
  logic            rb_q, rb_d;
  logic [ROWS-1:0] key_q, key_d;
  logic [ROWS-1:0] wl_d, wlb_d;
  logic            done_d, err_d;
  logic            ready;
  logic            reject;
  mode_t           mode_in;
  logic [ROWS-1:0] row_oh;

  cim_row_onehot #(.ROWS(ROWS), .AW(AW)) u_onehot (
    .addr   (row_q),
    .onehot (row_oh)
  );

  assign ready         = (state_q == S_IDLE) && cs;
  assign cmd.cmd_ready = ready;
  assign mode_in       = mode_t'(cmd.cmd_mode);
  // CAM ignores the address, so only WRITE/MAC are range checked.
  assign reject        = (mode_in == MODE_RSVD) ||
                         ((mode_in != MODE_CAM) && ({1'b0, cmd.cmd_addr} >= ROWS_EXT));
  assign busy          = (state_q != S_IDLE);
  assign row_idx       = row_q;
  assign dbg_state     = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    left_d  = left_q;
    mode_d  = mode_q;
    rb_d    = rb_q;
    key_d   = key_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wl_d    = '0;
    wlb_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = S_PRE;
            cnt_d   = '0;
            row_d   = cmd.cmd_addr;
            mode_d  = mode_in;
            rb_d    = cmd.cmd_read_bar;
            key_d   = cmd.cmd_key;
            left_d  = (mode_in == MODE_MAC) ? cmd.cmd_cnt : '0;
          end
        end
      end
      S_PRE: begin
        if (!cs) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_q == PRE_LAST) begin
          state_d = S_ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACT: begin
        if (!cs) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          if (left_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRE;
            left_d  = left_q - 1'b1;
            // Wrap at ROWS, which need not be a power of two.
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // ACT is only entered from PRE or held in ACT, and row_q only moves on
    // the ACT->PRE edge, so row_oh is already the row of the coming pulse.
    if (state_d == S_ACT) begin
      case (mode_q)
        MODE_WRITE: begin
          wl_d  = row_oh;
          wlb_d = row_oh;
        end
        MODE_MAC: begin
          wl_d  = rb_q ? '0 : row_oh;
          wlb_d = rb_q ? row_oh : '0;
        end
        MODE_CAM: begin
          wl_d  = key_q;
          wlb_d = ~key_q;
        end
        default: begin
          wl_d  = '0;
          wlb_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      left_q  <= '0;
      mode_q  <= MODE_WRITE;
      rb_q    <= 1'b0;
      key_q   <= '0;
      WL      <= '0;
      WLB     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      left_q  <= left_d;
      mode_q  <= mode_d;
      rb_q    <= rb_d;
      key_q   <= key_d;
      WL      <= wl_d;
      WLB     <= wlb_d;
      done    <= done_d;
      err     <= err_d;
    end
  end
endmodule

// File: doc/cim_row_sequencer.md
Name: cim_row_sequencer

Overview:
- Parametrised wordline sequencer for the CIM macro; drives WL/WLB for ROWS rows from a valid/ready command interface.
- Supports four modes:
  - single-row WRITE;
  - multi-row MAC sweep with read_bar polarity;
  - CAM search (WL=key, WLB=~key);
  - reserved, which is rejected.
- Each activation is framed by a programmable precharge gap and pulse width, replacing clock-gated wordlines with registered, glitch-free pulses.

Parameters:
ROWS, 16, number of wordline rows (>=2, need not be a power of two)
AW, $clog2(ROWS), row address width
PRE_CYC, 1, precharge cycles with all lines low before each pulse (>=1)
PULSE_CYC, 2, cycles each activation is held (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cs  in  1  chip select, active high; low aborts and forces lines low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE with cs=1
cmd_mode  in  2  00 WRITE, 01 MAC, 10 CAM, 11 reserved
cmd_addr  in  AW  start row
cmd_cnt  in  AW  MAC rows minus 1; ignored otherwise
cmd_read_bar  in  1  MAC polarity: 0 drives WL, 1 drives WLB
cmd_key  in  ROWS  CAM search key
WL  out  ROWS  wordlines, registered
WLB  out  ROWS  complementary wordlines, registered
row_idx  out  AW  row currently pre-charged/pulsed
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on rejected command or abort

Behaviour:
- Reset (rst=1 at edge): state IDLE; WL=WLB=0, row_idx=0, busy=0, done=0, err=0. Reset wins over every other input, including mid-operation.
- Handshake: the command is accepted at an edge where cmd_valid && cmd_ready. The command is latched; input fields are don't-care afterwards.
- Rejection: mode 11, or cmd_addr >= ROWS for WRITE/MAC:
  - err=1 next cycle;
  - stay in IDLE; no line ever rises.
- States:
  - IDLE.
  - PRE: lines 0, lasts PRE_CYC cycles.
  - ACT: lines driven, lasts PULSE_CYC cycles.
  - Transitions: after ACT, return to PRE if rows remain, else to IDLE with done=1 in the first IDLE cycle.
  - A cycle counter counts within PRE and ACT.
- Line values during ACT, with r = one-hot of the current row:
  - WRITE: WL=WLB=r.
  - MAC: read_bar=0 gives WL=r, WLB=0; read_bar=1 gives WL=0, WLB=r.
  - CAM: WL=key, WLB=~key; exactly one PRE+ACT.
- Outside ACT, WL=WLB=0 always.
- MAC sweep:
  - rows addr, addr+1, …, addr+cnt, wrapping ROWS-1 -> 0 (modulo ROWS, not 2^AW);
  - cnt >= ROWS-1 visits each row once per ROWS steps; the cnt+1 total is honoured.
- Timing: accept at edge T, so PRE occupies cycles T+1..T+PRE_CYC. The first ACT cycle is T+PRE_CYC+1. Each row costs PRE_CYC+PULSE_CYC cycles.
- done: asserted at T + (cnt+1)(PRE_CYC+PULSE_CYC) + 1. cmd_ready is high in the same cycle, so back-to-back commands start with a fresh PRE.
- cs=0 in any non-IDLE state:
  - next edge sets lines to 0 and the state to IDLE;
  - err=1 for one cycle; no done.
- cs=0 in IDLE: cmd_ready=0, lines stay 0.
- Invariant: WL&WLB is nonzero only in WRITE or CAM ACT. WL has at most one bit set except in CAM.

Decomposition:
- Package cim_pkg:
  - mode enum (MODE_WRITE, MODE_MAC, MODE_CAM, MODE_RSVD);
  - state enum (S_IDLE, S_PRE, S_ACT);
  - localparam for the counter width, $clog2(max(PRE_CYC,PULSE_CYC)+1).
- Sub-module cim_row_onehot (parameter ROWS): combinational AW -> ROWS decoder that outputs all zeros for addresses >= ROWS. It is instantiated once for the current row.

Test Plan:
- WRITE addr=5, PRE_CYC=1, PULSE_CYC=2, accept at T:
  - WL=WLB=0x0020 in T+2..T+3, zero otherwise;
  - done at T+4.
- MAC ROWS=16, addr=14, cnt=3, read_bar=1:
  - WLB pulses rows 14, 15, 0, 1 in order, each 2 cycles with a 1-cycle gap;
  - WL stays 0; done at T+13.
- CAM key=0xA5C3:
  - WL=0xA5C3, WLB=0x5A3C in T+2..T+3;
  - done at T+4; row_idx don't-care.
- Rejects: mode=11, and WRITE with addr=20 at ROWS=20. Each gives err=1 at T+1, no line activity, busy=0.
- Aborts: cs low during the second MAC ACT gives lines 0 next edge, err=1, no done. rst high mid-PRE gives all outputs 0 next edge, cmd_ready=1 after release.
- Back-to-back: cmd_valid held with two WRITEs (rows 0, 3). The second is accepted in the done cycle and its PRE follows immediately.
